// File: rtl/packed_lane_packer.sv
// Packs a stream of P_WIDTH-bit elements into a P_LANES-wide lane vector with a written-lane mask.
// Optional per-lane even parity on out_unpack_o is enabled by defining PACKED_LANE_PACKER_PARITY_EN.
module packed_lane_packer #(
  parameter int unsigned        P_LANES = 5,
  parameter int unsigned        P_WIDTH = 4,
  parameter logic [P_WIDTH-1:0] P_PAD   = '0
) (
  input  logic                              main_clk_i,
  input  logic                              main_rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [P_WIDTH-1:0]                in_data_i,
  input  logic                              in_last_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [P_LANES-1:0][P_WIDTH-1:0]   out_matrix_o,
  output logic [P_LANES-1:0]                out_vec_o,
  output logic [P_WIDTH-1:0]                out_vec_unpack_o [P_LANES-1:0],
  output logic                              out_unpack_o [P_LANES-1:0]
);

  localparam int unsigned      IDX_W    = (P_LANES > 1) ? $clog2(P_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_LANES - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [P_LANES-1:0][P_WIDTH-1:0] lane_q, lane_d;
  logic [P_LANES-1:0]              vec_q, vec_d;
  logic                            in_fire;

  // While a vector is held, input acceptance tracks the drain so a new vector starts without a bubble.
  assign in_ready_o  = (state_q == FILL) || out_ready_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == FULL);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    vec_d   = vec_q;
    if (state_q == FILL) begin
      if (in_fire) begin
        lane_d[idx_q] = in_data_i;
        vec_d[idx_q]  = 1'b1;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX || in_last_i) state_d = FULL;
      end
    end else if (out_ready_i) begin
      lane_d  = {P_LANES{P_PAD}};
      vec_d   = '0;
      idx_d   = '0;
      state_d = FILL;
      if (in_fire) begin
        lane_d[0] = in_data_i;
        vec_d[0]  = 1'b1;
        idx_d     = IDX_W'(1);
        if (in_last_i || P_LANES == 1) state_d = FULL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the lane array is reset too because unwritten lanes must read P_PAD.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state_q <= FILL;
      idx_q   <= '0;
      lane_q  <= {P_LANES{P_PAD}};
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
    end
  end

  assign out_matrix_o = lane_q;
  assign out_vec_o    = vec_q;

  for (genvar k = 0; k < P_LANES; k++) begin : g_copy
    assign out_vec_unpack_o[k] = lane_q[k];
  end

`ifdef PACKED_LANE_PACKER_PARITY_EN
  logic [P_LANES-1:0] par_q;

  // Parity is computed from the next lane value so it updates in the same cycle as the lane.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      par_q <= {P_LANES{^P_PAD}};
    end else begin
      for (int k = 0; k < P_LANES; k++) par_q[k] <= ^lane_d[k];
    end
  end

  for (genvar k = 0; k < P_LANES; k++) begin : g_par
    assign out_unpack_o[k] = par_q[k];
  end
`else
  for (genvar k = 0; k < P_LANES; k++) begin : g_par
    assign out_unpack_o[k] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_packed_lane_packer.sv
// Directed self-checking bench for packed_lane_packer (P_LANES=5, P_WIDTH=4, P_PAD=4'hA).
// Expected parity follows PACKED_LANE_PACKER_PARITY_EN when the bench is built with it.
module tb_packed_lane_packer;

  localparam int unsigned L = 5;
  localparam int unsigned W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, in_last, out_valid, out_ready;
  logic [W-1:0]          in_data;
  logic [L-1:0][W-1:0]   matrix;
  logic [L-1:0]          vec;
  logic [W-1:0]          vu [L-1:0];
  logic                  pu [L-1:0];
  logic [L-1:0][W-1:0]   vu_flat;
  logic [L-1:0]          pu_flat;

  int checks = 0;
  int errors = 0;

  packed_lane_packer #(.P_LANES(L), .P_WIDTH(W), .P_PAD(4'hA)) dut (
    .main_clk_i       (clk),
    .main_rst_i       (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_data_i        (in_data),
    .in_last_i        (in_last),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_matrix_o     (matrix),
    .out_vec_o        (vec),
    .out_vec_unpack_o (vu),
    .out_unpack_o     (pu)
  );

  always #5 clk = ~clk;

  always_comb begin
    vu_flat = '0;
    pu_flat = '0;
    for (int k = 0; k < L; k++) begin
      vu_flat[k] = vu[k];
      pu_flat[k] = pu[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (vec !== 5'h00) begin errors++; $display("FAIL reset_vec: got %h want 00", vec); end
    checks++; if (matrix !== 20'hAAAAA) begin errors++; $display("FAIL reset_matrix: got %h want AAAAA", matrix); end
    checks++; if (vu_flat !== 20'hAAAAA) begin errors++; $display("FAIL reset_unpack: got %h want AAAAA", vu_flat); end
    checks++; if (pu_flat !== 5'b00000) begin errors++; $display("FAIL reset_parity: got %b want 00000", pu_flat); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [L-1:0] vec_exp;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      vec_exp = L'((1 << i) - 1);
      checks++; if (vec !== vec_exp) begin errors++; $display("FAIL stream_vec[%0d]: got %h want %h", i, vec, vec_exp); end
      checks++; if (out_valid !== (i == 5)) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, (i == 5)); end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (matrix !== 20'h54321) begin errors++; $display("FAIL stream_matrix: got %h want 54321", matrix); end
    checks++; if (vu_flat !== 20'h54321) begin errors++; $display("FAIL stream_unpack: got %h want 54321", vu_flat); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
    checks++; if (vec !== 5'h00) begin errors++; $display("FAIL stream_drain_vec: got %h want 00", vec); end
    checks++; if (matrix !== 20'hAAAAA) begin errors++; $display("FAIL stream_drain_matrix: got %h want AAAAA", matrix); end
  endtask

  task automatic test_last();
    drive(1'b1, 4'h7, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'h9, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b want 1", out_valid); end
    checks++; if (matrix !== 20'hAAA97) begin errors++; $display("FAIL last_matrix: got %h want AAA97", matrix); end
    checks++; if (vec !== 5'h03) begin errors++; $display("FAIL last_vec: got %h want 03", vec); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      checks++; if (matrix !== 20'h54321) begin errors++; $display("FAIL bp_matrix[%0d]: got %h want 54321", c, matrix); end
      checks++; if (vec !== 5'h1F) begin errors++; $display("FAIL bp_vec[%0d]: got %h want 1F", c, vec); end
      tick();
    end
    drive(1'b1, 4'h6, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (matrix !== 20'hAAAA6) begin errors++; $display("FAIL bp_release_matrix: got %h want AAAA6", matrix); end
    checks++; if (vec !== 5'h01) begin errors++; $display("FAIL bp_release_vec: got %h want 01", vec); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] vals [5];
    vals = '{4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
    drive(1'b1, 4'h7, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'h8, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (vec !== 5'h07) begin errors++; $display("FAIL rstmid_pre_vec: got %h want 07", vec); end
    #2 rst = 1'b1;
    #1;
    checks++; if (vec !== 5'h00) begin errors++; $display("FAIL rstmid_vec: got %h want 00", vec); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    checks++; if (matrix !== 20'hAAAAA) begin errors++; $display("FAIL rstmid_matrix: got %h want AAAAA", matrix); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b want 1", out_valid); end
    checks++; if (matrix !== 20'hDCB98) begin errors++; $display("FAIL rstmid_new_matrix: got %h want DCB98", matrix); end
    checks++; if (vec !== 5'h1F) begin errors++; $display("FAIL rstmid_new_vec: got %h want 1F", vec); end
    tick();
  endtask

  task automatic test_last_no_valid();
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lastnv_valid: got %b want 0", out_valid); end
    checks++; if (vec !== 5'h01) begin errors++; $display("FAIL lastnv_vec: got %h want 01", vec); end
    drive(1'b1, 4'h2, 1'b0, 1'b1);
    tick();
    checks++; if (vec !== 5'h03) begin errors++; $display("FAIL lastnv_cont_vec: got %h want 03", vec); end
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'h4, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lastnv_full_valid: got %b want 1", out_valid); end
    checks++; if (vec !== 5'h1F) begin errors++; $display("FAIL lastnv_full_vec: got %h want 1F", vec); end
    checks++; if (matrix !== 20'h54321) begin errors++; $display("FAIL lastnv_full_matrix: got %h want 54321", matrix); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h7, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    checks++; if (vec !== 5'h01) begin errors++; $display("FAIL b2b_vec: got %h want 01", vec); end
    checks++; if (matrix !== 20'hAAAA7) begin errors++; $display("FAIL b2b_matrix: got %h want AAAA7", matrix); end
    drive(1'b1, 4'h2, 1'b0, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_next_valid: got %b want 0", out_valid); end
    checks++; if (matrix !== 20'hAAAA2) begin errors++; $display("FAIL b2b_next_matrix: got %h want AAAA2", matrix); end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checks++; if (vec !== 5'h01) begin errors++; $display("FAIL b2b_idle_vec: got %h want 01", vec); end
  endtask

  task automatic test_parity();
    logic [L-1:0] par_exp;
`ifdef PACKED_LANE_PACKER_PARITY_EN
    par_exp = 5'b00010;
`else
    par_exp = 5'b00000;
`endif
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'h7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (matrix !== 20'hAAA73) begin errors++; $display("FAIL parity_matrix: got %h want AAA73", matrix); end
    checks++; if (pu_flat !== par_exp) begin errors++; $display("FAIL parity_bits: got %b want %b", pu_flat, par_exp); end
    tick();
    checks++; if (pu_flat !== par_exp) begin errors++; $display("FAIL parity_hold: got %b want %b", pu_flat, par_exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_last();
    test_backpressure();
    test_reset_mid();
    test_last_no_valid();
    test_back_to_back();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packed_lane_packer.md
PACKED_LANE_PACKER -- requirements
Module: packed_lane_packer

Interface
REQ-001 SHALL have parameter P_LANES, default 5, number of lanes per output vector (1..16).
REQ-002 SHALL have parameter P_WIDTH, default 4, bits per lane element.
REQ-003 SHALL have parameter P_PAD [P_WIDTH-1:0], default 0, value driven on lanes not written in a vector.
REQ-004 SHALL have port main_clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port main_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid_i  input  1  input element valid.
REQ-007 SHALL have port in_ready_o  output  1  input element accepted when high with in_valid_i.
REQ-008 SHALL have port in_data_i  input  [P_WIDTH-1:0]  input element.
REQ-009 SHALL have port in_last_i  input  1  qualified by in_valid_i; closes the current vector early.
REQ-010 SHALL have port out_valid_o  output  1  output vector valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts vector when high with out_valid_o.
REQ-012 SHALL have port out_matrix_o  output  [P_LANES-1:0][P_WIDTH-1:0]  packed lane matrix.
REQ-013 SHALL have port out_vec_o  output  [P_LANES-1:0]  lane-written mask.
REQ-014 SHALL have port out_vec_unpack_o  output  [P_WIDTH-1:0] x unpacked [P_LANES-1:0]  element-for-element copy of out_matrix_o.
REQ-015 SHALL have port out_unpack_o  output  1 x unpacked [P_LANES-1:0]  per-lane even parity (see Configuration).

Function
REQ-016 SHALL implement FSM with states FILL and FULL plus lane index idx (clog2(P_LANES) bits, min 1).
REQ-017 FILL: in_ready_o=1, out_valid_o=0; handshake writes in_data_i to lane idx, sets out_vec_o[idx], idx+1.
REQ-018 FILL: handshake with idx==P_LANES-1 or in_last_i=1 SHALL move to FULL next cycle; otherwise stay FILL.
REQ-019 Latency: element accepted in cycle N SHALL be visible on out_matrix_o in cycle N+1; out_valid_o rises N+1 when vector closes.
REQ-020 FULL: out_valid_o=1; out_matrix_o, out_vec_o, out_vec_unpack_o, out_unpack_o SHALL hold stable until out_ready_i.
REQ-021 FULL: in_ready_o SHALL equal out_ready_i (zero-bubble).
REQ-022 FULL with out_ready_i=1 and no input handshake: next cycle FILL, idx=0, mask all-0, all lanes = P_PAD.
REQ-023 FULL with out_ready_i=1 and input handshake: new vector starts with element in lane 0, mask=1, idx=1, other lanes P_PAD; state FULL again if in_last_i=1 or P_LANES==1, else FILL.
REQ-024 in_last_i without in_valid_i SHALL be ignored; in_last_i on lane P_LANES-1 SHALL be equivalent to a full close.
REQ-025 Unwritten lanes SHALL always read P_PAD; out_vec_o SHALL be all-0 only while FILL with idx==0.
REQ-026 out_vec_unpack_o[k] SHALL equal out_matrix_o[k] combinationally for every k.

Reset
REQ-027 main_rst_i high SHALL immediately force state FILL, idx=0, out_valid_o=0, out_vec_o=0, all lanes P_PAD, out_unpack_o=parity(P_PAD), in_ready_o=1 after release.
REQ-028 Reset during FULL or partial FILL SHALL discard the vector; no partial vector emitted after release.

Configuration
REQ-029 Macro PACKED_LANE_PACKER_PARITY_EN defined: out_unpack_o[k] = XOR of out_matrix_o[k] bits, registered with the lane.
REQ-030 Macro undefined: port out_unpack_o SHALL remain present and drive constant 0; no parity logic.

Verification
REQ-031 P_LANES=5, P_WIDTH=4: stream 1,2,3,4,5 back-to-back, out_ready_i=1 -> one vector matrix {5,4,3,2,1} (lane4..0), out_vec_o=5'h1F, out_valid_o one cycle, in_ready_o never low.
REQ-032 Elements 7,9 with in_last_i on 9, P_PAD=4'hA -> matrix {A,A,A,9,7}, out_vec_o=5'h03.
REQ-033 Full vector with out_ready_i=0 for 3 cycles -> outputs stable, in_ready_o=0, input element held; release -> element 6 lands in lane 0 same cycle, out_vec_o=5'h01 next cycle.
REQ-034 Assert main_rst_i after 3 of 5 elements -> out_vec_o=0 and out_valid_o=0 immediately; next 5 elements form clean vector.
REQ-035 With PACKED_LANE_PACKER_PARITY_EN, lane values 4'h3,4'h7 -> out_unpack_o[0]=0, [1]=1; without macro -> all 0.
REQ-036 in_last_i=1 with in_valid_i=0 mid-vector -> no state change, vector continues filling.
